spi_reg_ctrl: RTL

//   Register-access sequencer behind spi_device, in the system clk domain.

---
 rtl/spi_reg_ctrl_pkg.sv | 34 +++
 rtl/spi_bus_timeout.sv | 35 +++
 rtl/spi_reg_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl_pkg : state encoding and byte constants for spi_reg_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_reg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_WR_BUS  = 3'd3,
    ST_RD_BUS  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

  localparam int         CMD_READ_BIT       = 7;
  localparam int         STATUS_OVERRUN_BIT = 7;
  localparam int         STATUS_TIMEOUT_BIT = 6;
  localparam logic [7:0] TX_IDLE            = 8'hFF;

  function automatic logic [7:0] status_byte(input logic overrun, input logic timeout);
    logic [7:0] s;
    s                     = '0;
    s[STATUS_OVERRUN_BIT] = overrun;
    s[STATUS_TIMEOUT_BIT] = timeout;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_bus_timeout.sv
// ---------------------------------------------------------------------------
// spi_bus_timeout : counts cycles of an outstanding bus request, flags expiry
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_bus_timeout #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int               CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // count holds k-1 during the k-th cycle of a request
  assign expired = run && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl : SPI byte stream to auto-incrementing register read/write bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = 7,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_active,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [7:0]           tx_data,
  output logic                 tx_ready,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [7:0]           reg_wdata,
  output logic                 reg_we,
  output logic                 reg_re,
  input  logic [7:0]           reg_rdata,
  input  logic                 reg_ack,
  output logic                 busy,
  output logic                 err_overrun,
  output logic                 err_timeout
);

  state_t     state;
  logic [7:0] rd_buf;
  logic       rd_buf_valid;
  logic       req;
  logic       req_idle;
  logic       expired;
  logic       timed_out;
  logic       bus_done;
  logic       set_ovr;
  logic       set_tmo;
  logic       clr_err;

  assign req       = reg_we | reg_re;
  assign req_idle  = ~req;
  assign timed_out = expired & ~reg_ack;
  assign bus_done  = req & (reg_ack | expired);
  assign busy      = (state != ST_IDLE);

  spi_bus_timeout #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (req_idle),
    .run    (req),
    .expired(expired)
  );

  // Error events; a new error in the STATUS-load cycle wins over the clear
  always_comb begin
    set_tmo = timed_out;
    set_ovr = 1'b0;
    clr_err = 1'b0;
    if (cs_active && rx_valid) begin
      case (state)
        ST_CMD:    clr_err = rx_data[CMD_READ_BIT];
        ST_WR_BUS: set_ovr = 1'b1;
        ST_RD_BUS: set_ovr = ~rd_buf_valid;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      tx_data      <= TX_IDLE;
      tx_ready     <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      rd_buf       <= '0;
      rd_buf_valid <= 1'b0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_overrun <= (err_overrun & ~clr_err) | set_ovr;
      err_timeout <= (err_timeout & ~clr_err) | set_tmo;

      if (state != ST_IDLE && state != ST_DRAIN && !cs_active) begin
        // chip select gone: finish an outstanding request, never start one
        if (req && !bus_done) begin
          state <= ST_DRAIN;
        end else begin
          state        <= ST_IDLE;
          reg_we       <= 1'b0;
          reg_re       <= 1'b0;
          tx_data      <= TX_IDLE;
          tx_ready     <= 1'b0;
          rd_buf_valid <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_active) state <= ST_CMD;
          end
          ST_CMD: begin
            if (rx_valid) begin
              reg_addr <= ADDR_BITS'({1'b0, rx_data[6:0]});
              if (rx_data[CMD_READ_BIT]) begin
                state    <= ST_RD_BUS;
                reg_re   <= 1'b1;
                tx_data  <= status_byte(err_overrun, err_timeout);
                tx_ready <= 1'b1;
              end else begin
                state <= ST_WR_WAIT;
              end
            end
          end
          ST_WR_WAIT: begin
            if (rx_valid) begin
              reg_wdata <= rx_data;
              reg_we    <= 1'b1;
              state     <= ST_WR_BUS;
            end
          end
          ST_WR_BUS: begin
            if (bus_done) begin
              reg_we   <= 1'b0;
              reg_addr <= reg_addr + ADDR_BITS'(1);
              state    <= ST_WR_WAIT;
            end
          end
          ST_RD_BUS: begin
            if (rx_valid && !rd_buf_valid) begin
              tx_data  <= TX_IDLE;
              tx_ready <= 1'b0;
            end
            if (bus_done) begin
              reg_re       <= 1'b0;
              rd_buf       <= reg_ack ? reg_rdata : TX_IDLE;
              rd_buf_valid <= 1'b1;
              state        <= ST_RD_WAIT;
            end
          end
          ST_RD_WAIT: begin
            if (rx_valid) begin
              tx_data      <= rd_buf;
              tx_ready     <= 1'b1;
              rd_buf_valid <= 1'b0;
              reg_addr     <= reg_addr + ADDR_BITS'(1);
              reg_re       <= 1'b1;
              state        <= ST_RD_BUS;
            end
          end
          ST_DRAIN: begin
            if (bus_done) begin
              reg_we       <= 1'b0;
              reg_re       <= 1'b0;
              tx_data      <= TX_IDLE;
              tx_ready     <= 1'b0;
              rd_buf_valid <= 1'b0;
              state        <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
